// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR access path: Zicsr funct3 encodings,
// privilege level encodings, the access controller FSM state enum and the
// CSR address pattern that marks a register as read-only.
// No ports (package).
// -----------------------------------------------------------------------------
package csr_pkg;

    // Zicsr funct3 encodings; bit 2 selects the immediate (zimm) operand.
    localparam logic [2:0] CSR_FN_RW  = 3'b001;
    localparam logic [2:0] CSR_FN_RS  = 3'b010;
    localparam logic [2:0] CSR_FN_RC  = 3'b011;
    localparam logic [2:0] CSR_FN_RWI = 3'b101;
    localparam logic [2:0] CSR_FN_RSI = 3'b110;
    localparam logic [2:0] CSR_FN_RCI = 3'b111;

    // Privilege levels (2'b10 is reserved).
    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    // csr[11:10] == 2'b11 marks a read-only CSR.
    localparam logic [1:0] CSR_RO_PATTERN = 2'b11;

    typedef enum logic [1:0] {
        CSR_ST_IDLE  = 2'd0,
        CSR_ST_READ  = 2'd1,
        CSR_ST_WRITE = 2'd2,
        CSR_ST_RESP  = 2'd3
    } csr_state_e;

endpackage

// File: rtl/csr_rmw_alu.sv
// -----------------------------------------------------------------------------
// csr_rmw_alu
// Combinational read-modify-write datapath for Zicsr instructions.
// Ports:
//   funct3_i     Zicsr funct3
//   old_i        current CSR value
//   rs1_data_i   rs1 register value (register forms)
//   rs1_idx_i    rs1 index / zimm (immediate forms and write suppression)
//   new_o        value to write back
//   do_write_o   instruction performs a write
//   illegal_op_o funct3 is not a Zicsr encoding (000 / 100)
// -----------------------------------------------------------------------------
module csr_rmw_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [4:0]      rs1_idx_i,
    output logic [XLEN-1:0] new_o,
    output logic            do_write_o,
    output logic            illegal_op_o
);

    logic [XLEN-1:0] op;

    always_comb begin
        op           = funct3_i[2] ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_data_i;
        new_o        = old_i;
        do_write_o   = 1'b0;
        illegal_op_o = 1'b0;
        case (funct3_i)
            CSR_FN_RW, CSR_FN_RWI: begin
                new_o      = op;
                do_write_o = 1'b1;
            end
            // Set/clear forms only write when the source index/zimm is
            // non-zero, regardless of the register value.
            CSR_FN_RS, CSR_FN_RSI: begin
                new_o      = old_i | op;
                do_write_o = (rs1_idx_i != 5'd0);
            end
            CSR_FN_RC, CSR_FN_RCI: begin
                new_o      = old_i & ~op;
                do_write_o = (rs1_idx_i != 5'd0);
            end
            default: begin
                illegal_op_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// -----------------------------------------------------------------------------
// csr_access_ctrl
// Initiator side of the CSR bus. Runs one Zicsr instruction at a time as a
// read-modify-write: IDLE (accept) -> READ (sample old value) -> WRITE
// (one-cycle strobe) -> RESP (hold result until writeback takes it).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_*                      instruction from execute (valid/ready)
//   priv                       current privilege, captured at accept
//   csr_addr/we/wdata/rdata    CSR bus; rdata is combinational from addr
//   resp_*                     result to writeback (valid/ready)
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds its payload stable while valid is high and
// ready is low.
// -----------------------------------------------------------------------------
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int PRIV_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [11:0]       req_csr,
    input  logic [4:0]        req_rs1_idx,
    input  logic [XLEN-1:0]   req_rs1_data,
    input  logic [4:0]        req_rd,
    input  logic [PRIV_W-1:0] priv,
    output logic [11:0]       csr_addr,
    output logic              csr_we,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [4:0]        resp_rd,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_illegal
);

    csr_state_e        state_q, state_d;
    logic [2:0]        fn_q;
    logic [11:0]       csr_q;
    logic [4:0]        idx_q;
    logic [XLEN-1:0]   data_q;
    logic [4:0]        rd_q;
    logic [PRIV_W-1:0] priv_q;
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   new_q;
    logic              wr_q;
    logic              ill_q;

    logic [XLEN-1:0]   alu_new;
    logic              alu_do_write;
    logic              alu_illegal_op;
    logic              ill_d;
    logic              accept;

    csr_rmw_alu #(.XLEN(XLEN)) u_alu (
        .funct3_i     (fn_q),
        .old_i        (csr_rdata),
        .rs1_data_i   (data_q),
        .rs1_idx_i    (idx_q),
        .new_o        (alu_new),
        .do_write_o   (alu_do_write),
        .illegal_op_o (alu_illegal_op)
    );

    // Privilege check is an unsigned 2-bit compare against csr[9:8].
    assign ill_d  = alu_illegal_op
                  | (csr_q[9:8] > 2'(priv_q))
                  | ((csr_q[11:10] == CSR_RO_PATTERN) & alu_do_write);
    assign accept = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CSR_ST_IDLE;
            fn_q    <= '0;
            csr_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            priv_q  <= '0;
            old_q   <= '0;
            new_q   <= '0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                fn_q   <= req_funct3;
                csr_q  <= req_csr;
                idx_q  <= req_rs1_idx;
                data_q <= req_rs1_data;
                rd_q   <= req_rd;
                priv_q <= priv;
            end
            if (state_q == CSR_ST_READ) begin
                old_q <= csr_rdata;
                new_q <= alu_new;
                wr_q  <= alu_do_write;
                ill_q <= ill_d;
            end
        end
    end

    // Outputs are forced to their idle values while reset is high so that a
    // strobe due in the reset cycle never reaches the bus.
    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        csr_addr     = '0;
        csr_we       = 1'b0;
        csr_wdata    = '0;
        resp_valid   = 1'b0;
        resp_rd      = '0;
        resp_data    = '0;
        resp_illegal = 1'b0;
        if (!reset) begin
            case (state_q)
                CSR_ST_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) state_d = CSR_ST_READ;
                end
                CSR_ST_READ: begin
                    csr_addr = csr_q;
                    state_d  = CSR_ST_WRITE;
                end
                CSR_ST_WRITE: begin
                    csr_addr  = csr_q;
                    csr_we    = wr_q & ~ill_q;
                    csr_wdata = new_q;
                    state_d   = CSR_ST_RESP;
                end
                CSR_ST_RESP: begin
                    resp_valid   = 1'b1;
                    resp_illegal = ill_q;
                    resp_data    = ill_q ? '0 : old_q;
                    resp_rd      = ill_q ? 5'd0 : rd_q;
                    if (resp_ready) state_d = CSR_ST_IDLE;
                end
                default: state_d = CSR_ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
Initiator side of the CSR bus. Executes Zicsr instructions (CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI) handed over by the execute stage, and performs a read-modify-write on the CSR register files over the shared csr_we/csr_addr/csr_wdata/csr_rdata bus. Checks privilege and read-only access. Returns the old CSR value, destination register and an illegal-instruction flag to writeback through a valid/ready handshake.

Parameters:
XLEN, 64, data width of CSR bus and GPR operands
PRIV_W, 2, width of current privilege level (0=U, 1=S, 3=M)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  instruction offered by execute stage
req_ready  out  1  controller can accept a request
req_funct3  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
req_csr  in  12  CSR address (instr[31:20])
req_rs1_idx  in  5  rs1 index; also zimm for the immediate forms
req_rs1_data  in  XLEN  rs1 register value
req_rd  in  5  destination register index
priv  in  PRIV_W  current privilege level, sampled at accept
csr_addr  out  12  CSR bus address
csr_we  out  1  CSR bus write strobe, one cycle
csr_wdata  out  XLEN  CSR bus write data
csr_rdata  in  XLEN  CSR bus read data, combinational from csr_addr
resp_valid  out  1  result available
resp_ready  in  1  writeback consumes result
resp_rd  out  5  destination index (forced 0 when illegal)
resp_data  out  XLEN  old CSR value (0 when illegal)
resp_illegal  out  1  raise illegal-instruction trap

Behaviour:
- Reset values: req_ready=0 during reset, then 1 in IDLE. csr_we=0, csr_addr=0, csr_wdata=0, resp_valid=0, resp_rd=0, resp_data=0, resp_illegal=0. FSM goes to IDLE.
- FSM states: IDLE -> READ -> WRITE -> RESP -> IDLE. Non-pipelined; one instruction is in flight at a time.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch funct3, csr, rs1_idx, rs1_data, rd and priv. Drive csr_addr from the latched csr. Go to READ.
- READ (cycle 1 after accept):
  - Sample csr_rdata into old_q.
  - Operand op = funct3[2] ? zero-extended rs1_idx : rs1_data.
  - new value:
    - RW: op
    - RS: old|op
    - RC: old&~op
  - do_write = RW-type, or (RS/RC-type and rs1_idx!=0). For RS/RC the write is suppressed when the rs1 index / zimm is zero, regardless of rs1_data.
  - illegal if any of:
    - funct3 is 000 or 100
    - csr[9:8] > priv
    - csr[11:10]==2'b11 and do_write
  - Go to WRITE.
- WRITE:
  - csr_we = do_write & ~illegal, asserted for exactly this cycle, with csr_wdata=new and csr_addr still held.
  - Go to RESP.
- RESP:
  - resp_valid=1 with resp_data=old_q, resp_rd=rd, resp_illegal=illegal.
  - When illegal: resp_data=0 and resp_rd=0.
  - Outputs are held stable until resp_ready. The RESP->IDLE transition happens on the cycle resp_valid&resp_ready.
  - req_ready returns to 1 the following cycle. There is no accept in the same cycle as the response handshake.
- Latency: accept at cycle 0, write strobe at cycle 2, resp_valid at cycle 3. Minimum throughput is one instruction per 4 cycles.
- A CSRRW with rd=0 still reads; there are no read side effects on the CSR files. resp_rd=0.
- csr_we is never asserted outside WRITE. csr_addr is held from accept through WRITE and returns to 0 in IDLE.
- Reset mid-operation: any state returns to IDLE next edge, and all outputs take their reset values. A write strobe pending for the next cycle is dropped.
- Widths: zimm is zero-extended to XLEN. The priv comparison is unsigned on 2 bits.

Decomposition:
- Shared package csr_pkg holds:
  - funct3 encodings (CSR_FN_RW/RS/RC/RWI/RSI/RCI)
  - privilege encodings (PRIV_U/S/M)
  - the FSM state enum (CSR_ST_IDLE/READ/WRITE/RESP)
  - the csr[11:10] read-only pattern constant
- One natural sub-module is csr_rmw_alu. It is combinational: funct3, old, rs1_data and rs1_idx in; new, do_write and illegal_op out. It is reused later by the interrupt/trap unit.

Test Plan:
1. CSRRW csr=0x040, rs1_data=0x1234, rd=5, priv=M, with the CSR preloaded to 0xAA -> csr_we pulses at cycle 2 with wdata=0x1234. resp at cycle 3 shows data=0xAA, rd=5, illegal=0. A readback returns 0x1234.
2. CSRRS csr=0x004, old=0x0F, rs1_data=0xF0, rs1_idx=3 -> wdata=0xFF. CSRRC with rs1_data=0x0F -> wdata=0xF0.
3. CSRRSI with zimm=0 on csr=0x000 -> csr_we never asserted, resp_data=old, illegal=0. CSRRS with rs1_idx=0 and rs1_data=0xFFFF -> no write.
4. CSRRW csr=0xC00 (read-only) -> no write, resp_illegal=1, rd=0, data=0. CSRRS rs1_idx=0 on 0xC00 -> legal read.
5. priv=U, CSRRW csr=0x300 -> illegal=1, no write. funct3=100 -> illegal=1.
6. Backpressure: resp_ready held 0 for 5 cycles -> resp outputs are stable and req_ready=0. Reset asserted in WRITE -> no csr_we, all outputs reset, and the next request completes normally.
